// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - multi-channel programmable clock divider with shadowed, glitch-free divisor updates
// Optional feature macro: CLKDIV_PHASE_SYNC_EN (adds sync_in to phase-align every channel)
module clock_divider_prog #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 8000
) (
   input  logic                                           bigClk,
   input  logic                                           reset,
   input  logic [NUM_CH-1:0]                              ch_en,
   input  logic                                           div_wr,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] div_ch,
   input  logic [CNT_W-1:0]                               div_val,
`ifdef CLKDIV_PHASE_SYNC_EN
   input  logic                                           sync_in,
`endif
   output logic [NUM_CH-1:0]                              smallClk,
   output logic [NUM_CH-1:0]                              tick,
   output logic [NUM_CH-1:0]                              div_pend
);

   localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

   // Phase-alignment request; tied off when the feature is not built in
   logic sync_w;
`ifdef CLKDIV_PHASE_SYNC_EN
   assign sync_w = sync_in;
`else
   assign sync_w = 1'b0;
`endif

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         localparam logic [CH_W-1:0] CH_IDX = CH_W'(g);

         logic [CNT_W-1:0] count_q, count_d;
         logic [CNT_W-1:0] active_q, active_d;
         logic [CNT_W-1:0] shadow_q, shadow_d;
         logic [CNT_W-1:0] shadow_eff;
         logic             clk_q, clk_d;
         logic             tick_q, tick_d;
         logic             pend_q, pend_d;
         logic             wr_hit, terminal, apply;

         // Next state: sync realign, count or terminal toggle, and shadow-to-active handoff.
         // A write landing on an apply cycle bypasses the shadow so it takes effect immediately.
         always_comb begin
            wr_hit     = div_wr && (div_ch == CH_IDX);
            terminal   = (count_q >= active_q);
            shadow_eff = wr_hit ? div_val : shadow_q;
            apply      = 1'b0;
            count_d    = count_q;
            active_d   = active_q;
            shadow_d   = wr_hit ? div_val : shadow_q;
            clk_d      = clk_q;
            tick_d     = 1'b0;
            pend_d     = pend_q;
            if (sync_w) begin
               // Realign: apply what was already pending; a same-cycle write stays pending
               count_d  = '0;
               clk_d    = 1'b0;
               active_d = shadow_q;
               pend_d   = wr_hit;
            end else begin
               apply = !ch_en[g] || terminal;
               if (ch_en[g]) begin
                  if (terminal) begin
                     count_d = '0;
                     clk_d   = ~clk_q;
                     tick_d  = 1'b1;
                  end else begin
                     count_d = count_q + CNT_W'(1);
                  end
               end
               if (apply) begin
                  active_d = shadow_eff;
                  pend_d   = 1'b0;
               end else if (wr_hit) begin
                  pend_d = 1'b1;
               end
            end
         end

         // Channel state registers with synchronous active-high reset
         always_ff @(posedge bigClk) begin
            if (reset) begin
               count_q  <= '0;
               active_q <= RST_DIV;
               shadow_q <= RST_DIV;
               clk_q    <= 1'b0;
               tick_q   <= 1'b0;
               pend_q   <= 1'b0;
            end else begin
               count_q  <= count_d;
               active_q <= active_d;
               shadow_q <= shadow_d;
               clk_q    <= clk_d;
               tick_q   <= tick_d;
               pend_q   <= pend_d;
            end
         end

         assign smallClk[g] = clk_q;
         assign tick[g]     = tick_q;
         assign div_pend[g] = pend_q;
      end
   endgenerate

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - directed self-checking bench for clock_divider_prog
module tb_clock_divider_prog;

   logic        bigClk = 1'b0;
   logic        reset;
   logic [2:0]  ch_en;
   logic        div_wr;
   logic [1:0]  div_ch;
   logic [15:0] div_val;
   logic        sync_in;
   logic [2:0]  smallClk;
   logic [2:0]  tick;
   logic [2:0]  div_pend;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   clock_divider_prog #(
      .NUM_CH     (3),
      .CNT_W      (16),
      .DEFAULT_DIV(8000)
   ) dut (
      .bigClk  (bigClk),
      .reset   (reset),
      .ch_en   (ch_en),
      .div_wr  (div_wr),
      .div_ch  (div_ch),
      .div_val (div_val),
`ifdef CLKDIV_PHASE_SYNC_EN
      .sync_in (sync_in),
`endif
      .smallClk(smallClk),
      .tick    (tick),
      .div_pend(div_pend)
   );

   always #5 bigClk = ~bigClk;

   typedef struct {
      logic [2:0]  en;
      logic        wr;
      logic [1:0]  ch;
      logic [15:0] val;
      logic [2:0]  exp_clk;
      logic [2:0]  exp_tick;
      logic [2:0]  exp_pend;
   } vec_t;

   vec_t vecs[$];

   task automatic push(input logic [2:0] en, input logic wr, input logic [1:0] ch,
                       input logic [15:0] val, input logic [2:0] c, input logic [2:0] t,
                       input logic [2:0] p);
      vec_t v;
      v.en = en; v.wr = wr; v.ch = ch; v.val = val;
      v.exp_clk = c; v.exp_tick = t; v.exp_pend = p;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge bigClk);
      #1;
      cyc++;
   endtask

   task automatic find_rises(input int n_steps);
      int   rise[3];
      logic prev[3];
      for (int i = 0; i < 3; i++) begin
         rise[i] = -1;
         prev[i] = smallClk[i];
      end
      for (int k = 0; k < n_steps; k++) begin
         step();
         for (int i = 0; i < 3; i++) begin
            if (smallClk[i] && !prev[i] && rise[i] < 0) rise[i] = cyc;
            prev[i] = smallClk[i];
         end
      end
      check("first_rise_ch0", rise[0], 8001);
      check("first_rise_ch1", rise[1], 8001);
      check("first_rise_ch2", rise[2], 8001);
   endtask

   initial begin
      int   rise0, fall0, tick_cnt, tick_first, tick_last, skew, pend_drop;
      logic prev0;
      bit   found;

      reset = 1'b1; ch_en = 3'b111; div_wr = 1'b0; div_ch = '0; div_val = '0; sync_in = 1'b0;

      // Reset state
      step(); step();
      check("rst_smallClk", int'(smallClk), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_div_pend", int'(div_pend), 0);

      // Default divisor: rise at 8001, fall at 16002, tick only on those cycles
      reset = 1'b0; cyc = 0;
      rise0 = -1; fall0 = -1; tick_cnt = 0; tick_first = -1; tick_last = -1; skew = 0;
      prev0 = 1'b0;
      for (int k = 0; k < 16005; k++) begin
         step();
         if (smallClk[0] && !prev0 && rise0 < 0) rise0 = cyc;
         if (!smallClk[0] && prev0 && fall0 < 0) fall0 = cyc;
         prev0 = smallClk[0];
         if (tick[0]) begin
            tick_cnt++;
            if (tick_first < 0) tick_first = cyc;
            tick_last = cyc;
         end
         if (smallClk != {3{smallClk[0]}} || tick != {3{tick[0]}}) skew++;
      end
      check("t1_rise", rise0, 8001);
      check("t1_fall", fall0, 16002);
      check("t1_tick_count", tick_cnt, 2);
      check("t1_tick_first", tick_first, 8001);
      check("t1_tick_last", tick_last, 16002);
      check("t1_channels_aligned", skew, 0);

      // Mid-half-period write to ch1: pending next cycle, applied at the old terminal (24003)
      div_wr = 1'b1; div_ch = 2'd1; div_val = 16'd3;
      step();
      div_wr = 1'b0;
      check("t2_pend_set", int'(div_pend), 3'b010);
      found = 1'b0; pend_drop = 0;
      for (int k = 0; k < 9000 && !found; k++) begin
         step();
         if (tick[1]) found = 1'b1;
         else if (!div_pend[1]) pend_drop++;
      end
      check("t2_term_found", int'(found), 1);
      check("t2_term_cycle", cyc, 24003);
      check("t2_pend_held", pend_drop, 0);
      check("t2_pend_clear", int'(div_pend), 0);
      check("t2_clk_at_term", int'(smallClk), 3'b111);
      check("t2_tick_at_term", int'(tick), 3'b111);

      // Per-cycle vectors: 4-cycle half period, write on terminal, out-of-range write, ch1 pause
      repeat (3) push(3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b000, 3'b000);
      push(3'b111, 1'b0, 2'd0, 16'd0, 3'b101, 3'b010, 3'b000);
      repeat (3) push(3'b111, 1'b0, 2'd0, 16'd0, 3'b101, 3'b000, 3'b000);
      push(3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b010, 3'b000);
      repeat (3) push(3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b000, 3'b000);
      push(3'b111, 1'b1, 2'd1, 16'd5, 3'b101, 3'b010, 3'b000);
      repeat (5) push(3'b111, 1'b0, 2'd0, 16'd0, 3'b101, 3'b000, 3'b000);
      push(3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b010, 3'b000);
      push(3'b111, 1'b1, 2'd3, 16'd1, 3'b111, 3'b000, 3'b000);
      repeat (4) push(3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b000, 3'b000);
      push(3'b111, 1'b0, 2'd0, 16'd0, 3'b101, 3'b010, 3'b000);
      repeat (2) push(3'b111, 1'b0, 2'd0, 16'd0, 3'b101, 3'b000, 3'b000);
      repeat (10) push(3'b101, 1'b0, 2'd0, 16'd0, 3'b101, 3'b000, 3'b000);
      repeat (3) push(3'b111, 1'b0, 2'd0, 16'd0, 3'b101, 3'b000, 3'b000);
      push(3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b010, 3'b000);

      foreach (vecs[i]) begin
         ch_en = vecs[i].en; div_wr = vecs[i].wr; div_ch = vecs[i].ch; div_val = vecs[i].val;
         step();
         check($sformatf("vec%0d_smallClk", i), int'(smallClk), int'(vecs[i].exp_clk));
         check($sformatf("vec%0d_tick", i), int'(tick), int'(vecs[i].exp_tick));
         check($sformatf("vec%0d_div_pend", i), int'(div_pend), int'(vecs[i].exp_pend));
      end
      div_wr = 1'b0; ch_en = 3'b111;

      // ch0 divisor 0, applied by a one-cycle disable: toggles every cycle, tick stuck high
      div_wr = 1'b1; div_ch = 2'd0; div_val = 16'd0;
      step();
      div_wr = 1'b0;
      check("t3_pend_set", int'(div_pend[0]), 1);
      ch_en = 3'b110;
      step();
      check("t3_pend_applied", int'(div_pend[0]), 0);
      check("t3_hold_clk", int'(smallClk[0]), 1);
      check("t3_hold_tick", int'(tick[0]), 0);
      ch_en = 3'b111;
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("t3_toggle%0d", k), int'(smallClk[0]), k % 2);
         check($sformatf("t3_tick%0d", k), int'(tick[0]), 1);
      end

      // Reset with a pending write discards it and restores the default divisor
      div_wr = 1'b1; div_ch = 2'd2; div_val = 16'd7;
      step();
      div_wr = 1'b0;
      check("t6_pend_set", int'(div_pend), 3'b100);
      reset = 1'b1;
      step();
      check("t6_rst_smallClk", int'(smallClk), 0);
      check("t6_rst_tick", int'(tick), 0);
      check("t6_rst_div_pend", int'(div_pend), 0);
      reset = 1'b0; cyc = 0;
      find_rises(8010);
      check("t6_pend_after", int'(div_pend), 0);

`ifdef CLKDIV_PHASE_SYNC_EN
      // Sync pulse forces all channels low and realigns their next rise
      sync_in = 1'b1;
      step();
      sync_in = 1'b0;
      check("sync_smallClk", int'(smallClk), 0);
      check("sync_tick", int'(tick), 0);
      cyc = 0;
      find_rises(8005);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
